// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state/step encodings and helpers for the LCD port arbiter
//
// Purpose: HD44780 init command bytes, DDRAM line bases, transfer-engine state
// and step encodings, plus helpers mapping a step to its controller byte.
// Ports: none (package).
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_HOME     = 8'h80;  // DDRAM address 0

  localparam logic [7:0] LINE1 = 8'h80;
  localparam logic [7:0] LINE2 = 8'hC0;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_NEXT   = 3'd3,
    ST_IDLE   = 3'd4
  } eng_state_e;

  typedef enum logic [2:0] {
    STEP_INIT0 = 3'd0,
    STEP_INIT1 = 3'd1,
    STEP_INIT2 = 3'd2,
    STEP_INIT3 = 3'd3,
    STEP_INIT4 = 3'd4,
    STEP_ADDR  = 3'd5,
    STEP_CHAR  = 3'd6
  } step_e;

  // Controller byte for a step; ADDR/CHAR use the captured write.
  function automatic logic [7:0] step_data(step_e step, logic row,
                                           logic [3:0] col, logic [7:0] ch);
    case (step)
      STEP_INIT0: return CMD_FUNC_SET;
      STEP_INIT1: return CMD_DISP_ON;
      STEP_INIT2: return CMD_CLEAR;
      STEP_INIT3: return CMD_ENTRY;
      STEP_INIT4: return CMD_HOME;
      STEP_ADDR:  return (row ? LINE2 : LINE1) | {4'b0000, col};
      STEP_CHAR:  return ch;
      default:    return 8'h00;
    endcase
  endfunction

  function automatic step_e step_next(step_e step);
    case (step)
      STEP_INIT0: return STEP_INIT1;
      STEP_INIT1: return STEP_INIT2;
      STEP_INIT2: return STEP_INIT3;
      STEP_INIT3: return STEP_INIT4;
      STEP_ADDR:  return STEP_CHAR;
      default:    return STEP_INIT0;
    endcase
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// rtl/lcd_rr_arbiter.sv - round-robin grant with registered pointer
//
// Purpose: picks the first asserted request at or after the pointer (cyclic).
// The pointer moves to winner+1 only when i_ld is high.
// Ports:
//   i_clock, i_reset : clock, async active-high reset (pointer -> 0)
//   i_req   [N]      : request vector
//   i_ld             : accept current winner, advance pointer
//   o_grant [N]      : one-hot combinational grant (zero if no request)
//   o_any            : at least one request present
//   o_win   [PW]     : index of the winning requester
module lcd_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [N-1:0]  i_req,
  input  logic          i_ld,
  output logic [N-1:0]  o_grant,
  output logic          o_any,
  output logic [PW-1:0] o_win
);

  logic [PW-1:0] r_ptr;

  always_comb begin
    int idx;
    idx     = 0;
    o_any   = 1'b0;
    o_win   = '0;
    o_grant = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!o_any && i_req[idx]) begin
        o_any = 1'b1;
        o_win = idx[PW-1:0];
      end
    end
    if (o_any) o_grant[o_win] = 1'b1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_ld && o_any) begin
      r_ptr <= (o_win == PW'(N - 1)) ? '0 : o_win + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_port_arbiter.sv
// rtl/lcd_port_arbiter.sv - shares one character-LCD controller between several requesters
//
// Purpose: runs the HD44780 init sequence after reset, then serves
// single-character writes (DDRAM address + data) for NUM_REQ requesters
// in round-robin order, with a settle delay after every controller transfer.
// Ports:
//   clock, reset         : clock, async active-high reset (restarts init)
//   req      [NUM_REQ]   : write requests, held until the matching gnt bit
//   req_pos  [5*NUM_REQ] : per requester {row, col[3:0]}
//   req_char [8*NUM_REQ] : per requester ASCII code
//   gnt      [NUM_REQ]   : one-cycle one-hot accept pulse
//   busy, init_done      : status
//   ctl_data/ctl_rs/ctl_start, ctl_done : LCD controller handshake
module lcd_port_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DLY_MAX = 262142,
  parameter int DLY_W   = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*5-1:0] req_pos,
  input  logic [NUM_REQ*8-1:0] req_char,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 init_done,
  output logic [7:0]           ctl_data,
  output logic                 ctl_rs,
  output logic                 ctl_start,
  input  logic                 ctl_done
);

  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  eng_state_e r_state;
  step_e      r_step;
  logic [DLY_W-1:0] r_cnt;
  logic       r_row;
  logic [3:0] r_col;
  logic [7:0] r_char;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_any;
  logic [PW-1:0]      w_win;
  logic               w_ld;

  // The pointer only moves when a grant is actually issued from IDLE.
  assign w_ld = (r_state == ST_IDLE) && w_any;

  lcd_rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .i_clock (clock),
    .i_reset (reset),
    .i_req   (req),
    .i_ld    (w_ld),
    .o_grant (w_grant),
    .o_any   (w_any),
    .o_win   (w_win)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_START;
      r_step    <= STEP_INIT0;
      r_cnt     <= '0;
      r_row     <= 1'b0;
      r_col     <= 4'h0;
      r_char    <= 8'h00;
      gnt       <= '0;
      busy      <= 1'b1;
      init_done <= 1'b0;
      ctl_data  <= 8'h00;
      ctl_rs    <= 1'b0;
      ctl_start <= 1'b0;
    end else begin
      gnt <= '0;
      case (r_state)
        ST_START: begin
          ctl_data  <= step_data(r_step, r_row, r_col, r_char);
          ctl_rs    <= (r_step == STEP_CHAR);
          ctl_start <= 1'b1;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ctl_done) begin
            ctl_start <= 1'b0;
            r_state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == DLY_W'(DLY_MAX)) begin
            r_cnt   <= '0;
            r_state <= ST_NEXT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          if (r_step == STEP_INIT4 || r_step == STEP_CHAR) begin
            if (r_step == STEP_INIT4) init_done <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_step  <= step_next(r_step);
            r_state <= ST_START;
          end
        end
        ST_IDLE: begin
          // IDLE is only reachable after init, so no grant can precede init_done.
          if (w_any) begin
            gnt     <= w_grant;
            r_row   <= req_pos[5*int'(w_win)+4];
            r_col   <= req_pos[5*int'(w_win) +: 4];
            r_char  <= req_char[8*int'(w_win) +: 8];
            r_step  <= STEP_ADDR;
            busy    <= 1'b1;
            r_state <= ST_START;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_port_arbiter.sv
// tb/tb_lcd_port_arbiter.sv - scoreboard testbench for lcd_port_arbiter
module tb_lcd_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DLY_MAX = 4;
  localparam int DLY_W   = 18;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*5-1:0] req_pos;
  logic [NUM_REQ*8-1:0] req_char;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  logic                 init_done;
  logic [7:0]           ctl_data;
  logic                 ctl_rs;
  logic                 ctl_start;
  logic                 ctl_done = 1'b0;

  int total = 0;
  int bad   = 0;
  int lat   = 3;
  int m_cnt = 0;

  always #5 clock = ~clock;

  lcd_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DLY_MAX (DLY_MAX),
    .DLY_W   (DLY_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_pos   (req_pos),
    .req_char  (req_char),
    .gnt       (gnt),
    .busy      (busy),
    .init_done (init_done),
    .ctl_data  (ctl_data),
    .ctl_rs    (ctl_rs),
    .ctl_start (ctl_start),
    .ctl_done  (ctl_done)
  );

  // Controller model: one-cycle done pulse 'lat' cycles after start rises.
  always @(posedge clock) begin
    if (ctl_start && !ctl_done) begin
      if (m_cnt == lat - 1) begin
        ctl_done <= 1'b1;
        m_cnt    <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      ctl_done <= 1'b0;
      m_cnt    <= 0;
    end
  end

  // Scoreboard: kind 0 = grant, kind 1 = controller transfer
  typedef struct packed {
    logic       kind;
    logic       rs;
    logic [7:0] val;
  } ev_t;

  ev_t q[$];

  task automatic push_g(input logic [1:0] g);
    ev_t e;
    e.kind = 1'b0; e.rs = 1'b0; e.val = {6'b0, g};
    q.push_back(e);
  endtask

  task automatic push_x(input logic rs, input logic [7:0] v);
    ev_t e;
    e.kind = 1'b1; e.rs = rs; e.val = v;
    q.push_back(e);
  endtask

  task automatic push_init();
    push_x(1'b0, 8'h38);
    push_x(1'b0, 8'h0C);
    push_x(1'b0, 8'h01);
    push_x(1'b0, 8'h06);
    push_x(1'b0, 8'h80);
  endtask

  // Monitor
  logic [NUM_REQ-1:0] prev_gnt   = '0;
  logic               prev_start = 1'b0;
  logic               prev_done  = 1'b0;
  logic [8:0]         cap        = '0;

  always @(negedge clock) begin
    ev_t e;
    if (gnt != '0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL gnt_unexpected got=%b exp=none", gnt);
      end else begin
        e = q.pop_front();
        if (e.kind != 1'b0 || e.val != {6'b0, gnt}) begin
          bad++;
          $display("FAIL gnt_order got=gnt:%b exp=kind%0d rs%0d val=%h", gnt, e.kind, e.rs, e.val);
        end
      end
      total++;
      if (prev_gnt != '0) begin
        bad++;
        $display("FAIL gnt_width got=two-cycle exp=one-cycle");
      end
    end
    if (ctl_start && !prev_start) begin
      total++;
      cap = {ctl_rs, ctl_data};
      if (q.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected got=rs%0d %h exp=none", ctl_rs, ctl_data);
      end else begin
        e = q.pop_front();
        if (e.kind != 1'b1 || e.rs != ctl_rs || e.val != ctl_data) begin
          bad++;
          $display("FAIL xfer got=rs%0d %h exp=kind%0d rs%0d %h", ctl_rs, ctl_data, e.kind, e.rs, e.val);
        end
      end
    end else if (ctl_start && prev_start) begin
      total++;
      if ({ctl_rs, ctl_data} != cap) begin
        bad++;
        $display("FAIL xfer_stable got=%h exp=%h", {ctl_rs, ctl_data}, cap);
      end
    end
    if (prev_done && prev_start) begin
      total++;
      if (ctl_start) begin
        bad++;
        $display("FAIL start_drop got=1 exp=0");
      end
    end
    prev_gnt   = gnt;
    prev_start = ctl_start;
    prev_done  = ctl_done;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_gnt(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (gnt == '0 && n < 300);
    chk({name, "_gnt_timeout"}, (gnt != '0), 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < 2000);
    chk({name, "_idle_timeout"}, busy, 0);
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!init_done && n < 2000);
    chk({name, "_init_timeout"}, init_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; req = '0; req_pos = '0; req_char = '0;
    repeat (3) @(negedge clock);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_ctl_data", ctl_data, 0);
    chk("rst_ctl_rs", ctl_rs, 0);
    chk("rst_ctl_start", ctl_start, 0);

    // Init sequence with both requests pending: no grant may appear
    push_init();
    req = 2'b11; req_pos = 10'h3FF; req_char = 16'h4242;
    reset = 1'b0;
    @(negedge clock);
    chk("busy_in_init", busy, 1);
    wait_init("init");
    chk("busy_after_init", busy, 0);
    req = '0;

    // Single write from requester 0: row 1, col 3, 'A'
    req_pos[4:0] = {1'b1, 4'h3}; req_char[7:0] = 8'h41;
    push_g(2'b01); push_x(1'b0, 8'hC3); push_x(1'b1, 8'h41);
    req = 2'b01;
    wait_gnt("w0");
    req = '0;
    wait_idle("w0");

    // Requester 1: row 0, col F, 'z'; inputs change after grant
    req_pos[9:5] = {1'b0, 4'hF}; req_char[15:8] = 8'h7A;
    push_g(2'b10); push_x(1'b0, 8'h8F); push_x(1'b1, 8'h7A);
    req = 2'b10;
    wait_gnt("w1");
    req = '0; req_char[15:8] = 8'h00; req_pos[9:5] = 5'h10;
    wait_idle("w1");

    // Both held: strict alternation, two transfers per grant
    req_pos = {5'b1_0010, 5'b0_0001}; req_char = {8'h31, 8'h30};
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        push_g(2'b01); push_x(1'b0, 8'h81); push_x(1'b1, 8'h30);
      end else begin
        push_g(2'b10); push_x(1'b0, 8'hC2); push_x(1'b1, 8'h31);
      end
    end
    req = 2'b11;
    for (int i = 0; i < 4; i++) wait_gnt("rr");
    req = '0;
    wait_idle("rr");

    // Slow controller: start held for the whole wait, drops after done
    lat = 20;
    req_pos[4:0] = {1'b0, 4'h5}; req_char[7:0] = 8'h55;
    push_g(2'b01); push_x(1'b0, 8'h85); push_x(1'b1, 8'h55);
    req = 2'b01;
    wait_gnt("slow");
    req = '0;
    n = 0;
    while (!ctl_start && n < 50) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (ctl_start && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("slow_start_cycles", n, 21);
    wait_idle("slow");
    lat = 3;

    // Reset during the CHAR transfer wait
    req_pos[4:0] = {1'b1, 4'h0}; req_char[7:0] = 8'h21;
    push_g(2'b01); push_x(1'b0, 8'hC0); push_x(1'b1, 8'h21);
    req = 2'b01;
    wait_gnt("rst");
    req = '0;
    n = 0;
    while (!(ctl_start && ctl_rs) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("rst_reach_char", ctl_start && ctl_rs, 1);
    push_init();
    #2 reset = 1'b1;
    #1;
    chk("rst_async_start", ctl_start, 0);
    chk("rst_async_init_done", init_done, 0);
    chk("rst_async_busy", busy, 1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    wait_init("reinit");

    repeat (5) @(negedge clock);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
